issue_pair_buffer: RTL and testbench

Dual-issue front end of the SPU pipeline: holds one fetched instruction pair (instr1 older, instr2 younger) and routes it to the even and odd issue slots. It presents the routed candidates to the hazard unit and consumes that unit's verdicts in the same cycle:
- `stall` holds the pair.
- `dependent_stall` splits it into two single issues.
- `flush` discards it and redirects fetch.

It sits between fetch/predecode and the register-fetch pipeline registers, and also maintains issue statistics counters.

---
 rtl/issue_pair_buffer_pkg.sv | 23 ++
 rtl/issue_pair_buffer_router.sv | 55 +++++
 rtl/issue_pair_buffer.sv | 136 +++++++++++++
 tb/tb_issue_pair_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_pair_buffer_pkg.sv
// Shared constants for the SPU dual-issue front end: nop words, stop opcode,
// pipe encodings and the pair-buffer state type.
package issue_pair_buffer_pkg;

  localparam logic [0:31] NOP_WORD  = 32'h40200000;
  localparam logic [0:31] LNOP_WORD = 32'h00200000;
  localparam logic [0:10] OP_STOP   = 11'b00000000000;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PAIR   = 2'd1,
    SECOND = 2'd2,
    HALT   = 2'd3
  } state_t;

  function automatic logic is_stop(input logic [0:31] word);
    return word[0:10] == OP_STOP;
  endfunction

endpackage

// File: rtl/issue_pair_buffer_router.sv
// Combinational slot router: places the held instruction(s) into the even/odd
// issue slots and fills vacant slots with the matching nop word.
import issue_pair_buffer_pkg::*;

module issue_router #(
  parameter int PC_W = 32
) (
  input  state_t          i_state,
  input  logic [0:31]     i_instr1,
  input  logic [0:31]     i_instr2,
  input  logic            i_type1,
  input  logic            i_type2,
  input  logic [0:PC_W-1] i_pc,
  output logic [0:31]     o_cand_even,
  output logic [0:31]     o_cand_odd,
  output logic [0:PC_W-1] o_pc_even,
  output logic [0:PC_W-1] o_pc_odd,
  output logic            o_i1_shown,
  output logic            o_i2_shown
);

  logic [0:PC_W-1] w_pc2;
  assign w_pc2 = i_pc + PC_W'(4);

  always_comb begin
    o_cand_even = NOP_WORD;
    o_cand_odd  = LNOP_WORD;
    o_pc_even   = '0;
    o_pc_odd    = '0;
    o_i1_shown  = (i_state == PAIR);
    // instr2 shares the cycle with instr1 only when they target different pipes
    o_i2_shown  = ((i_state == PAIR) && (i_type1 != i_type2)) || (i_state == SECOND);

    if (o_i1_shown) begin
      if (i_type1 == PIPE_ODD) begin
        o_cand_odd = i_instr1;
        o_pc_odd   = i_pc;
      end else begin
        o_cand_even = i_instr1;
        o_pc_even   = i_pc;
      end
    end

    if (o_i2_shown) begin
      if (i_type2 == PIPE_ODD) begin
        o_cand_odd = i_instr2;
        o_pc_odd   = w_pc2;
      end else begin
        o_cand_even = i_instr2;
        o_pc_even   = w_pc2;
      end
    end
  end

endmodule

// File: rtl/issue_pair_buffer.sv
// Dual-issue pair buffer: holds one fetched pair, presents routed candidates to
// the hazard unit and advances on its stall / dependent_stall / flush verdicts.
import issue_pair_buffer_pkg::*;

module issue_pair_buffer #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [0:PC_W-1]  fetch_pc,
  input  logic [0:31]      fetch_instr1,
  input  logic [0:31]      fetch_instr2,
  input  logic             instr1_type,
  input  logic             instr2_type,
  input  logic             stall,
  input  logic             dependent_stall,
  input  logic             flush,
  input  logic [0:PC_W-1]  branch_target,
  output logic [0:31]      cand_instr_even,
  output logic [0:31]      cand_instr_odd,
  output logic [0:PC_W-1]  cand_pc_even,
  output logic [0:PC_W-1]  cand_pc_odd,
  output logic             issue_even,
  output logic             issue_odd,
  output logic             redirect_valid,
  output logic [0:PC_W-1]  redirect_pc,
  output logic             halted,
  output logic [0:CNT_W-1] stall_cycles,
  output logic [0:CNT_W-1] dual_issues
);

  state_t           r_state;
  logic [0:PC_W-1]  r_pc;
  logic [0:31]      r_instr1;
  logic [0:31]      r_instr2;
  logic             r_type1;
  logic             r_type2;
  logic             r_redirect_valid;
  logic [0:PC_W-1]  r_redirect_pc;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_dual_issues;

  logic w_i1_shown, w_i2_shown;
  logic w_base, w_iss1, w_iss2, w_stop_iss, w_accept;

  issue_router #(.PC_W(PC_W)) u_router (
    .i_state     (r_state),
    .i_instr1    (r_instr1),
    .i_instr2    (r_instr2),
    .i_type1     (r_type1),
    .i_type2     (r_type2),
    .i_pc        (r_pc),
    .o_cand_even (cand_instr_even),
    .o_cand_odd  (cand_instr_odd),
    .o_pc_even   (cand_pc_even),
    .o_pc_odd    (cand_pc_odd),
    .o_i1_shown  (w_i1_shown),
    .o_i2_shown  (w_i2_shown)
  );

  assign w_base = !stall && !flush && (r_state != HALT);
  assign w_iss1 = w_i1_shown && w_base;
  // A younger instruction paired with a stop never issues: it is discarded with the pair
  assign w_iss2 = w_i2_shown && w_base &&
                  !((r_state == PAIR) && (dependent_stall || is_stop(r_instr1)));
  assign w_stop_iss = (w_iss1 && is_stop(r_instr1)) || (w_iss2 && is_stop(r_instr2));

  assign issue_even = (w_iss1 && (r_type1 == PIPE_EVEN)) || (w_iss2 && (r_type2 == PIPE_EVEN));
  assign issue_odd  = (w_iss1 && (r_type1 == PIPE_ODD))  || (w_iss2 && (r_type2 == PIPE_ODD));

  assign fetch_ready = !flush && (r_state != HALT) && !w_stop_iss &&
                       ((r_state == EMPTY) || w_iss2);
  assign w_accept    = fetch_valid && fetch_ready;

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign halted         = (r_state == HALT);
  assign stall_cycles   = r_stall_cycles;
  assign dual_issues    = r_dual_issues;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= EMPTY;
      r_pc             <= '0;
      r_instr1         <= '0;
      r_instr2         <= '0;
      r_type1          <= 1'b0;
      r_type2          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_stall_cycles   <= '0;
      r_dual_issues    <= '0;
    end else begin
      r_redirect_valid <= flush;
      if (flush)
        r_redirect_pc <= branch_target;
      if (issue_even && issue_odd)
        r_dual_issues <= r_dual_issues + CNT_W'(1);

      if (w_accept) begin
        r_pc     <= fetch_pc;
        r_instr1 <= fetch_instr1;
        r_instr2 <= fetch_instr2;
        r_type1  <= instr1_type;
        r_type2  <= instr2_type;
      end

      if (flush) begin
        if (r_state != HALT)
          r_state <= EMPTY;
      end else if (stall && ((r_state == PAIR) || (r_state == SECOND))) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept)
              r_state <= PAIR;
          end
          PAIR, SECOND: begin
            if (w_stop_iss)
              r_state <= HALT;
            else if (w_iss2)
              r_state <= w_accept ? PAIR : EMPTY;
            else if (w_iss1)
              r_state <= SECOND;
          end
          default: r_state <= HALT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_pair_buffer.sv
// Directed bench for issue_pair_buffer: stimulus queues expected issues, a
// negedge monitor pops and compares each issued slot.
module tb_issue_pair_buffer;

  localparam logic [31:0] NOP  = 32'h40200000;
  localparam logic [31:0] LNOP = 32'h00200000;
  localparam logic [31:0] ADD  = 32'h18008183;
  localparam logic [31:0] AI   = 32'h1C010204;
  localparam logic [31:0] LQD  = 32'h34000204;
  localparam logic [31:0] STOP = 32'h00000123;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_pc, fetch_instr1, fetch_instr2;
  logic        instr1_type, instr2_type;
  logic        stall, dependent_stall, flush;
  logic [31:0] branch_target;
  logic [31:0] cand_instr_even, cand_instr_odd, cand_pc_even, cand_pc_odd;
  logic        issue_even, issue_odd, redirect_valid, halted;
  logic [31:0] redirect_pc, stall_cycles, dual_issues;

  typedef struct {
    logic        slot;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  issue_pair_buffer dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_instr1(fetch_instr1), .fetch_instr2(fetch_instr2),
    .instr1_type(instr1_type), .instr2_type(instr2_type),
    .stall(stall), .dependent_stall(dependent_stall), .flush(flush),
    .branch_target(branch_target),
    .cand_instr_even(cand_instr_even), .cand_instr_odd(cand_instr_odd),
    .cand_pc_even(cand_pc_even), .cand_pc_odd(cand_pc_odd),
    .issue_even(issue_even), .issue_odd(issue_odd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .stall_cycles(stall_cycles), .dual_issues(dual_issues)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required end before 100000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end else
      $display("ok   %s = 0x%08h", name, act);
  endtask

  task automatic push(input logic slot, input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.slot = slot; e.instr = instr; e.pc = pc;
    exp_q.push_back(e);
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] i1, input logic t1,
                       input logic [31:0] i2, input logic t2);
    fetch_valid = 1'b1; fetch_pc = pc;
    fetch_instr1 = i1; instr1_type = t1;
    fetch_instr2 = i2; instr2_type = t2;
  endtask

  task automatic mon_issue(input logic slot, input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_issue: got slot %0d instr 0x%08h pc 0x%08h, required no issue",
               slot, instr, pc);
    end else begin
      e = exp_q.pop_front();
      if (e.slot !== slot || e.instr !== instr || e.pc !== pc) begin
        failures++;
        $display("FAIL issue: got slot %0d instr 0x%08h pc 0x%08h, required slot %0d instr 0x%08h pc 0x%08h",
                 slot, instr, pc, e.slot, e.instr, e.pc);
      end else
        $display("ok   issue slot %0d instr 0x%08h pc 0x%08h", slot, instr, pc);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (issue_even) mon_issue(1'b0, cand_instr_even, cand_pc_even);
      if (issue_odd)  mon_issue(1'b1, cand_instr_odd, cand_pc_odd);
    end
  end

  initial begin
    reset = 1'b0; fetch_valid = 1'b0; fetch_pc = '0;
    fetch_instr1 = '0; fetch_instr2 = '0; instr1_type = 1'b0; instr2_type = 1'b0;
    stall = 1'b0; dependent_stall = 1'b0; flush = 1'b0; branch_target = '0;
    tick(); tick();
    reset = 1'b1;
    #2;
    chk("rst_cand_even", cand_instr_even, NOP);
    chk("rst_cand_odd", cand_instr_odd, LNOP);
    chk("rst_issue", {30'd0, issue_even, issue_odd}, 32'd0);
    chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_counters", stall_cycles | dual_issues, 32'd0);
    chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);

    // 1: add (even) + lqd (odd) dual issue
    push(1'b0, ADD, 32'h100); push(1'b1, LQD, 32'h104);
    offer(32'h100, ADD, 1'b0, LQD, 1'b1);
    tick(); fetch_valid = 1'b0; #2;
    chk("t1_issue_both", {30'd0, issue_even, issue_odd}, 32'd3);
    chk("t1_pc_even", cand_pc_even, 32'h100);
    chk("t1_pc_odd", cand_pc_odd, 32'h104);
    chk("t1_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    tick(); #2;
    chk("t1_dual_issues", dual_issues, 32'd1);

    // 2: two even instructions split over two cycles
    push(1'b0, ADD, 32'h120); push(1'b0, AI, 32'h124);
    offer(32'h120, ADD, 1'b0, AI, 1'b0);
    tick(); fetch_valid = 1'b0; #2;
    chk("t2_odd_lnop", cand_instr_odd, LNOP);
    chk("t2_issue_c1", {30'd0, issue_even, issue_odd}, 32'd2);
    chk("t2_ready_c1", {31'd0, fetch_ready}, 32'd0);
    tick(); #2;
    chk("t2_even_instr2", cand_instr_even, AI);
    chk("t2_ready_c2", {31'd0, fetch_ready}, 32'd1);
    tick(); #2;
    chk("t2_dual_unchanged", dual_issues, 32'd1);

    // 3: differing types split by dependent_stall
    push(1'b1, LQD, 32'h140); push(1'b0, ADD, 32'h144);
    offer(32'h140, LQD, 1'b1, ADD, 1'b0);
    tick(); fetch_valid = 1'b0; dependent_stall = 1'b1; #2;
    chk("t3_issue_c1", {30'd0, issue_even, issue_odd}, 32'd1);
    tick(); dependent_stall = 1'b0; #2;
    chk("t3_issue_c2", {30'd0, issue_even, issue_odd}, 32'd2);
    chk("t3_pc_even", cand_pc_even, 32'h144);
    tick(); #2;
    chk("t3_dual_unchanged", dual_issues, 32'd1);

    // 4: three stall cycles hold the pair
    push(1'b0, ADD, 32'h160); push(1'b1, LQD, 32'h164);
    offer(32'h160, ADD, 1'b0, LQD, 1'b1);
    tick(); fetch_valid = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t4_stall_issue", {30'd0, issue_even, issue_odd}, 32'd0);
      chk("t4_stall_cand", cand_instr_even, ADD);
      tick();
    end
    stall = 1'b0; #2;
    chk("t4_stall_cycles", stall_cycles, 32'd3);
    chk("t4_release_issue", {30'd0, issue_even, issue_odd}, 32'd3);
    tick(); #2;
    chk("t4_dual_issues", dual_issues, 32'd2);

    // 5: flush while in SECOND, then a two-cycle flush in EMPTY
    push(1'b0, ADD, 32'h180);
    offer(32'h180, ADD, 1'b0, AI, 1'b0);
    tick(); fetch_valid = 1'b0;
    tick(); flush = 1'b1; branch_target = 32'h200; #2;
    chk("t5_flush_no_issue", {30'd0, issue_even, issue_odd}, 32'd0);
    chk("t5_flush_ready", {31'd0, fetch_ready}, 32'd0);
    tick(); flush = 1'b0; #2;
    chk("t5_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t5_redirect_pc", redirect_pc, 32'h200);
    chk("t5_empty_cand", cand_instr_even, NOP);
    chk("t5_empty_ready", {31'd0, fetch_ready}, 32'd1);
    tick(); flush = 1'b1; branch_target = 32'h300; #2;
    chk("t5_pulse_end", {31'd0, redirect_valid}, 32'd0);
    tick(); branch_target = 32'h340; #2;
    chk("t5_pulse1_pc", redirect_pc, 32'h300);
    tick(); flush = 1'b0; #2;
    chk("t5_pulse2_valid", {31'd0, redirect_valid}, 32'd1);
    chk("t5_pulse2_pc", redirect_pc, 32'h340);

    // 6: stop as instr1 halts; reset recovers
    push(1'b1, STOP, 32'h1C0);
    offer(32'h1C0, STOP, 1'b1, LQD, 1'b1);
    tick(); fetch_valid = 1'b0; #2;
    chk("t6_stop_issue", {30'd0, issue_even, issue_odd}, 32'd1);
    chk("t6_stop_ready", {31'd0, fetch_ready}, 32'd0);
    tick(); fetch_valid = 1'b1; #2;
    chk("t6_halted", {31'd0, halted}, 32'd1);
    chk("t6_halt_ready", {31'd0, fetch_ready}, 32'd0);
    chk("t6_halt_issue", {30'd0, issue_even, issue_odd}, 32'd0);
    tick(); #2;
    chk("t6_halted_hold", {31'd0, halted}, 32'd1);
    reset = 1'b0; fetch_valid = 1'b0;
    tick(); reset = 1'b1; #2;
    chk("t6_rst_halted", {31'd0, halted}, 32'd0);
    chk("t6_rst_stall_cycles", stall_cycles, 32'd0);
    chk("t6_rst_dual_issues", dual_issues, 32'd0);
    chk("t6_rst_ready", {31'd0, fetch_ready}, 32'd1);

    tick(); tick();
    chk("pending_issues", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
